// File: rtl/sprite_nav_fsm.sv
// sprite_nav_fsm: a single-sprite frame controller. Once per frame it erases
// the sprite, decodes a direction key, clamps the candidate position to the
// play field, checks the candidate against the obstacle memory, moves if the
// cell is clear, redraws the sprite and tests for the win cell.
module sprite_nav_fsm #(
  parameter int XW      = 8,
  parameter int YW      = 7,
  parameter int X_MAX   = 159,
  parameter int Y_MAX   = 119,
  parameter int X_START = 0,
  parameter int Y_START = 0,
  parameter int STEP    = 1,
  parameter int TICKS   = 833333,
  parameter int TW      = 20,
  parameter int WIN_X   = 159,
  parameter int WIN_Y   = 119
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [2:0]    key,
  input  logic          obs_hit,
  output logic [XW-1:0] obs_x,
  output logic [YW-1:0] obs_y,
  output logic [XW-1:0] xpos,
  output logic [YW-1:0] ypos,
  output logic          plot,
  output logic          s_color,
  output logic          win,
  output logic [3:0]    state_cur
);

  typedef enum logic [3:0] {
    S_INIT     = 4'd0,
    S_WAIT     = 4'd1,
    S_ERASE    = 4'd2,
    S_READ_KEY = 4'd3,
    S_OBS_ADDR = 4'd4,
    S_OBS_TEST = 4'd5,
    S_UPDATE   = 4'd6,
    S_DRAW     = 4'd7,
    S_CHECK    = 4'd8,
    S_WIN      = 4'd9
  } state_t;

  // Clamp arithmetic is carried one bit wider than the coordinate so that
  // neither the subtract nor the add can wrap.
  localparam logic [XW:0]   STEP_X = (XW+1)'(STEP);
  localparam logic [XW:0]   X_TOP  = (XW+1)'(X_MAX);
  localparam logic [XW:0]   X_LIM  = (XW+1)'(X_MAX - STEP);
  localparam logic [YW:0]   STEP_Y = (YW+1)'(STEP);
  localparam logic [YW:0]   Y_TOP  = (YW+1)'(Y_MAX);
  localparam logic [YW:0]   Y_LIM  = (YW+1)'(Y_MAX - STEP);
  localparam logic [TW-1:0] T_LOAD = TW'(TICKS - 1);

  state_t        state, state_nxt;
  logic [TW-1:0] timer;
  logic          tick;
  logic [XW:0]   xe, nx;
  logic [YW:0]   ye, ny;
  logic          key_move;
  logic          go_obs;
  logic          at_win;
  logic [XW-1:0] cand_x, cx;
  logic [YW-1:0] cand_y, cy;

  assign tick      = (timer == '0);
  assign at_win    = (xpos == XW'(WIN_X)) && (ypos == YW'(WIN_Y));
  assign state_cur = state;

  // Frame timer: free-running down-counter, one tick per TICKS clocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) timer <= T_LOAD;
    else        timer <= tick ? T_LOAD : timer - 1'b1;
  end

  // Key decode and clamped candidate position; a candidate equal to the
  // current position means the sprite is pressed against a wall.
  always_comb begin
    xe       = {1'b0, xpos};
    ye       = {1'b0, ypos};
    nx       = xe;
    ny       = ye;
    key_move = 1'b1;
    case (key)
      3'd1:    nx = (xe < STEP_X) ? '0    : xe - STEP_X;
      3'd2:    nx = (xe > X_LIM)  ? X_TOP : xe + STEP_X;
      3'd3:    ny = (ye < STEP_Y) ? '0    : ye - STEP_Y;
      3'd4:    ny = (ye > Y_LIM)  ? Y_TOP : ye + STEP_Y;
      default: key_move = 1'b0;
    endcase
    go_obs = key_move && !((nx == xe) && (ny == ye));
    cand_x = nx[XW-1:0];
    cand_y = ny[YW-1:0];
  end

  // Next-state logic of the frame sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_INIT:     state_nxt = S_DRAW;
      S_WAIT:     if (tick) state_nxt = S_ERASE;
      S_ERASE:    state_nxt = S_READ_KEY;
      S_READ_KEY: state_nxt = go_obs ? S_OBS_ADDR : S_DRAW;
      S_OBS_ADDR: state_nxt = S_OBS_TEST;
      S_OBS_TEST: state_nxt = obs_hit ? S_DRAW : S_UPDATE;
      S_UPDATE:   state_nxt = S_DRAW;
      S_DRAW:     state_nxt = S_CHECK;
      S_CHECK:    state_nxt = at_win ? S_WIN : S_WAIT;
      S_WIN:      state_nxt = S_WIN;
      default:    state_nxt = S_INIT;
    endcase
  end

  // State register, position/candidate registers and outputs registered
  // from the next state so they line up exactly with state_cur.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_INIT;
      xpos    <= XW'(X_START);
      ypos    <= YW'(Y_START);
      cx      <= '0;
      cy      <= '0;
      plot    <= 1'b0;
      s_color <= 1'b0;
      win     <= 1'b0;
      obs_x   <= '0;
      obs_y   <= '0;
    end else begin
      state   <= state_nxt;
      plot    <= (state_nxt == S_ERASE) || (state_nxt == S_DRAW);
      s_color <= (state_nxt == S_DRAW);
      win     <= (state_nxt == S_WIN);
      if (state == S_READ_KEY) begin
        cx <= cand_x;
        cy <= cand_y;
      end
      if (state == S_UPDATE) begin
        xpos <= cx;
        ypos <= cy;
      end
      // Obstacle address: presented from the fresh candidate on entry,
      // then held from the latched copy while obs_hit is sampled.
      if (state_nxt == S_OBS_ADDR) begin
        obs_x <= cand_x;
        obs_y <= cand_y;
      end else if (state_nxt == S_OBS_TEST) begin
        obs_x <= cx;
        obs_y <= cy;
      end else begin
        obs_x <= '0;
        obs_y <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_nav_fsm.sv
// Bench for sprite_nav_fsm: four instances with different step/start/win
// settings run side by side off one clock and one reset. A frame-level model
// predicts every output of every instance each cycle; directed literal
// checks pin the model at hand-computed points.
module tb_sprite_nav_fsm;
  localparam int NI = 4;

  function automatic int p_step(int i); return (i == 1 || i == 3) ? 4 : 1; endfunction
  function automatic int p_xs(int i);   return (i == 1) ? 2 : (i == 3) ? 158 : 0; endfunction
  function automatic int p_wx(int i);   return (i == 2) ? 2 : 159; endfunction
  function automatic int p_wy(int i);   return (i == 2) ? 0 : 119; endfunction

  typedef struct packed {
    logic [3:0] st;
    logic       plot;
    logic       col;
    logic       win;
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] ox;
    logic [6:0] oy;
  } rec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] key_v  [NI];
  logic       hit_v  [NI];
  logic [7:0] ox_v   [NI];
  logic [6:0] oy_v   [NI];
  logic [7:0] x_v    [NI];
  logic [6:0] y_v    [NI];
  logic       plot_v [NI];
  logic       col_v  [NI];
  logic       win_v  [NI];
  logic [3:0] st_v   [NI];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    sprite_nav_fsm #(
      .XW(8), .YW(7), .X_MAX(159), .Y_MAX(119),
      .X_START(p_xs(g)), .Y_START(0), .STEP(p_step(g)),
      .TICKS(16), .TW(5), .WIN_X(p_wx(g)), .WIN_Y(p_wy(g))
    ) u_dut (
      .clk(clk), .reset(reset), .key(key_v[g]), .obs_hit(hit_v[g]),
      .obs_x(ox_v[g]), .obs_y(oy_v[g]), .xpos(x_v[g]), .ypos(y_v[g]),
      .plot(plot_v[g]), .s_color(col_v[g]), .win(win_v[g]),
      .state_cur(st_v[g])
    );
  end

  // ---------------- frame-level model ----------------
  rec_t plan [NI][8];
  int   plen [NI];
  int   pidx [NI];
  rec_t cur  [NI];
  int   mt   [NI];
  int   mx   [NI];
  int   my   [NI];

  function automatic rec_t mk(int st, int pl, int co, int wn, int x, int y, int ox, int oy);
    rec_t r;
    r.st = 4'(st); r.plot = 1'(pl); r.col = 1'(co); r.win = 1'(wn);
    r.x = 8'(x); r.y = 7'(y); r.ox = 8'(ox); r.oy = 7'(oy);
    return r;
  endfunction

  task automatic push(int i, rec_t r);
    plan[i][plen[i]] = r;
    plen[i]++;
  endtask

  // Draw, win test, then the resting state the sprite settles into.
  task automatic push_tail(int i);
    push(i, mk(7, 1, 1, 0, mx[i], my[i], 0, 0));
    push(i, mk(8, 0, 0, 0, mx[i], my[i], 0, 0));
    if (mx[i] == p_wx(i) && my[i] == p_wy(i)) push(i, mk(9, 0, 0, 1, mx[i], my[i], 0, 0));
    else                                     push(i, mk(1, 0, 0, 0, mx[i], my[i], 0, 0));
  endtask

  task automatic model_reset(int i);
    mx[i] = p_xs(i); my[i] = 0; mt[i] = 15;
    cur[i] = mk(0, 0, 0, 0, mx[i], my[i], 0, 0);
    plen[i] = 0; pidx[i] = 0;
    push_tail(i);
  endtask

  // Whole frame predicted at the tick from the key and obstacle inputs,
  // which the stimulus holds steady across a frame.
  task automatic build_frame(int i);
    int  s, tx, ty;
    bit  mv;
    s = p_step(i); tx = mx[i]; ty = my[i]; mv = 1'b1;
    plen[i] = 0; pidx[i] = 0;
    push(i, mk(2, 1, 0, 0, mx[i], my[i], 0, 0));
    push(i, mk(3, 0, 0, 0, mx[i], my[i], 0, 0));
    case (int'(key_v[i]))
      1: tx = (mx[i] < s) ? 0 : mx[i] - s;
      2: tx = (mx[i] > 159 - s) ? 159 : mx[i] + s;
      3: ty = (my[i] < s) ? 0 : my[i] - s;
      4: ty = (my[i] > 119 - s) ? 119 : my[i] + s;
      default: mv = 1'b0;
    endcase
    if (mv && !(tx == mx[i] && ty == my[i])) begin
      push(i, mk(4, 0, 0, 0, mx[i], my[i], tx, ty));
      push(i, mk(5, 0, 0, 0, mx[i], my[i], tx, ty));
      if (!hit_v[i]) begin
        push(i, mk(6, 0, 0, 0, mx[i], my[i], 0, 0));
        mx[i] = tx; my[i] = ty;
      end
    end
    push_tail(i);
  endtask

  task automatic model_step(int i);
    bit tk;
    tk = (mt[i] == 0);
    mt[i] = tk ? 15 : mt[i] - 1;
    if (pidx[i] < plen[i]) begin
      cur[i] = plan[i][pidx[i]];
      pidx[i]++;
    end else if (cur[i].st == 4'd1 && tk) begin
      build_frame(i);
      cur[i] = plan[i][0];
      pidx[i] = 1;
    end
  endtask

  // Per-cycle compare of every instance against the model.
  initial begin
    rec_t act;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        if (!reset) model_reset(i);
        act.st = st_v[i]; act.plot = plot_v[i]; act.col = col_v[i]; act.win = win_v[i];
        act.x = x_v[i]; act.y = y_v[i]; act.ox = ox_v[i]; act.oy = oy_v[i];
        n_chk++;
        if (act !== cur[i]) begin
          n_fail++;
          $display("FAIL model_cmp dut%0d t=%0t got st=%0d plot=%0b col=%0b win=%0b pos=(%0d,%0d) obs=(%0d,%0d) expected st=%0d plot=%0b col=%0b win=%0b pos=(%0d,%0d) obs=(%0d,%0d)",
                   i, $time, act.st, act.plot, act.col, act.win, act.x, act.y, act.ox, act.oy,
                   cur[i].st, cur[i].plot, cur[i].col, cur[i].win, cur[i].x, cur[i].y, cur[i].ox, cur[i].oy);
        end
        if (reset) model_step(i);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic step_to(int c);
    while (cyc < c) begin
      @(posedge clk);
      #2;
      cyc++;
    end
  endtask

  task automatic set_in(int k0, int k1, int k2, int k3, int h0);
    key_v[0] = 3'(k0); key_v[1] = 3'(k1); key_v[2] = 3'(k2); key_v[3] = 3'(k3);
    hit_v[0] = 1'(h0);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      key_v[i] = '0;
      hit_v[i] = 1'b0;
    end
    #1 reset = 1'b0;
    repeat (3) begin @(posedge clk); #2; end
    chk("rst_state", int'(st_v[0]), 0);
    chk("rst_plot", int'(plot_v[0]), 0);
    chk("rst_obs_x", int'(ox_v[0]), 0);
    chk("rst_x_dut1", int'(x_v[1]), 2);
    chk("rst_x_dut3", int'(x_v[3]), 158);
    reset = 1'b1;
    cyc = 0;

    step_to(1);
    chk("init_draw_state", int'(st_v[0]), 7);
    chk("init_draw_plot", int'(plot_v[0]), 1);
    chk("init_draw_col", int'(col_v[0]), 1);
    step_to(2);  chk("init_check", int'(st_v[0]), 8);
    step_to(3);  chk("init_wait", int'(st_v[0]), 1);
    chk("wait_plot", int'(plot_v[0]), 0);
    set_in(2, 1, 2, 2, 0);
    step_to(15); chk("no_early_tick", int'(st_v[0]), 1);
    step_to(16);
    chk("erase_state", int'(st_v[0]), 2);
    chk("erase_plot", int'(plot_v[0]), 1);
    chk("erase_col", int'(col_v[0]), 0);
    step_to(18);
    chk("obs_addr_state", int'(st_v[0]), 4);
    chk("obs_addr_x", int'(ox_v[0]), 1);
    chk("obs_addr_y", int'(oy_v[0]), 0);
    step_to(19);
    chk("obs_test_state", int'(st_v[0]), 5);
    chk("obs_test_x", int'(ox_v[0]), 1);
    step_to(20); chk("update_state", int'(st_v[0]), 6);
    step_to(21);
    chk("moved_draw_state", int'(st_v[0]), 7);
    chk("moved_x", int'(x_v[0]), 1);
    chk("moved_col", int'(col_v[0]), 1);
    chk("left_clamp_x_dut1", int'(x_v[1]), 0);
    chk("right_clamp_x_dut3", int'(x_v[3]), 159);
    chk("step_x_dut2", int'(x_v[2]), 1);

    step_to(26);
    set_in(1, 5, 2, 2, 0);
    step_to(34);
    chk("wall_right_dut3", int'(st_v[3]), 7);
    chk("key5_none_dut1", int'(st_v[1]), 7);
    chk("key5_x_dut1", int'(x_v[1]), 0);
    step_to(37); chk("back_left_x", int'(x_v[0]), 0);
    step_to(39);
    chk("win_state_dut2", int'(st_v[2]), 9);
    chk("win_flag_dut2", int'(win_v[2]), 1);

    step_to(42);
    set_in(2, 0, 2, 0, 1);
    step_to(48); chk("win_no_plot_dut2", int'(plot_v[2]), 0);
    step_to(51);
    chk("blk_test_state", int'(st_v[0]), 5);
    chk("blk_test_obs_x", int'(ox_v[0]), 1);
    step_to(52);
    chk("blocked_draw", int'(st_v[0]), 7);
    chk("blocked_x", int'(x_v[0]), 0);
    step_to(54); chk("blocked_wait", int'(st_v[0]), 1);

    step_to(58);
    set_in(1, 1, 2, 0, 0);
    step_to(65); chk("wall_read_obs_x", int'(ox_v[0]), 0);
    step_to(66);
    chk("wall_left_draw", int'(st_v[0]), 7);
    chk("wall_left_x", int'(x_v[0]), 0);
    chk("wall_left_dut1", int'(st_v[1]), 7);
    chk("win_sticky_dut2", int'(win_v[2]), 1);

    step_to(74);
    set_in(2, 0, 0, 0, 0);
    step_to(83);
    chk("pre_rst_state", int'(st_v[0]), 5);
    chk("pre_rst_obs_x", int'(ox_v[0]), 1);
    reset = 1'b0;
    #1;
    chk("async_rst_state", int'(st_v[0]), 0);
    chk("async_rst_x", int'(x_v[0]), 0);
    chk("async_rst_plot", int'(plot_v[0]), 0);
    chk("async_rst_obs_x", int'(ox_v[0]), 0);
    chk("async_rst_win_dut2", int'(win_v[2]), 0);
    chk("async_rst_x_dut3", int'(x_v[3]), 158);
    repeat (2) begin @(posedge clk); #2; end
    set_in(4, 3, 4, 1, 0);
    reset = 1'b1;
    cyc = 0;

    step_to(21);
    chk("down_y", int'(y_v[0]), 1);
    chk("up_wall_dut1_state", int'(st_v[1]), 1);
    chk("up_wall_dut1_x", int'(x_v[1]), 2);
    chk("down_y_dut2", int'(y_v[2]), 1);
    chk("left4_x_dut3", int'(x_v[3]), 154);
    step_to(24);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
